// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC, selects the next PC (increment,
// branch/jump, jalr, trap), flags misaligned targets and captures EPC.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     ALIGN        = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            br_take,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] epc
);

  localparam logic [XLEN-1:0] STEP = XLEN'(2 ** ALIGN);

  typedef enum logic {BOOT, RUN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic            pc_valid_q, pc_valid_d;
  logic [XLEN-1:0] tgt;
  logic            jump;
  logic            tgt_mis;

  assign pc_plus  = pc_q + STEP;
  assign pc       = pc_q;
  assign epc      = epc_q;
  assign redirect = redirect_q;
  assign misalign = misalign_q;
  assign pc_valid = pc_valid_q;

  // Next-PC selection; outside RUN with en=1 the PC simply holds.
  always_comb begin
    state_d    = RUN;
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    jump       = jalr | jal | br_take;
    tgt        = jalr ? ((rs1 + imm) & ~XLEN'(1)) : (pc_q + imm);
    tgt_mis    = |tgt[ALIGN-1:0];
    pc_valid_d = (state_d == RUN);
    if (state_q == RUN && en) begin
      if (trap_req) begin
        pc_d       = TRAP_VECTOR;
        epc_d      = pc_q;
        redirect_d = 1'b1;
      end else if (jump) begin
        redirect_d = 1'b1;
        if (tgt_mis) begin
          pc_d       = TRAP_VECTOR;
          epc_d      = pc_q;
          misalign_d = 1'b1;
        end else begin
          pc_d = tgt;
        end
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      pc_valid_q <= pc_valid_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: vector tables with a scoreboard queue, plus reset/boot
// sequences, on a word-aligned and a halfword-aligned instance.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_c = 1'b1;
  logic        en = 1'b0, br_take = 1'b0, jal = 1'b0, jalr = 1'b0, trap_req = 1'b0;
  logic [31:0] imm = '0, rs1 = '0;

  logic [31:0] pc_a, pc_plus_a, epc_a;
  logic        pc_valid_a, redirect_a, misalign_a;
  logic [31:0] pc_b, pc_plus_b, epc_b;
  logic        pc_valid_b, redirect_b, misalign_b;

  pc_unit #(.XLEN(32), .ALIGN(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .br_take(br_take), .jal(jal), .jalr(jalr),
    .imm(imm), .rs1(rs1), .trap_req(trap_req), .pc(pc_a), .pc_plus(pc_plus_a),
    .pc_valid(pc_valid_a), .redirect(redirect_a), .misalign(misalign_a), .epc(epc_a)
  );

  pc_unit #(.XLEN(32), .ALIGN(1)) u_c (
    .clk(clk), .rst(rst_c), .en(en), .br_take(br_take), .jal(jal), .jalr(jalr),
    .imm(imm), .rs1(rs1), .trap_req(trap_req), .pc(pc_b), .pc_plus(pc_plus_b),
    .pc_valid(pc_valid_b), .redirect(redirect_b), .misalign(misalign_b), .epc(epc_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en, br, jl, jr, trap;
    logic [31:0] imm, rs1, pc, epc;
    logic        red, mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc, epc;
    logic        red, mis;
  } exp_t;

  exp_t sb[$];
  vec_t va[25];
  vec_t vb[6];

  function automatic vec_t mk(logic e, logic b, logic jl, logic jr, logic t,
                              logic [31:0] im, logic [31:0] r1,
                              logic [31:0] p, logic [31:0] ep, logic rd, logic ms);
    vec_t v;
    v.en = e; v.br = b; v.jl = jl; v.jr = jr; v.trap = t;
    v.imm = im; v.rs1 = r1; v.pc = p; v.epc = ep; v.red = rd; v.mis = ms;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; br_take = 1'b0; jal = 1'b0; jalr = 1'b0; trap_req = 1'b0;
    imm = '0; rs1 = '0;
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(vec_t v, bit alt, int idx);
    exp_t e;
    string tag;
    @(negedge clk);
    en = v.en; br_take = v.br; jal = v.jl; jalr = v.jr; trap_req = v.trap;
    imm = v.imm; rs1 = v.rs1;
    e.pc = v.pc; e.epc = v.epc; e.red = v.red; e.mis = v.mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tag = $sformatf("%s%0d", alt ? "c" : "w", idx);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (!alt) begin
        chk({tag, " pc"}, pc_a, e.pc);
        chk({tag, " epc"}, epc_a, e.epc);
        chk({tag, " redirect"}, 32'(redirect_a), 32'(e.red));
        chk({tag, " misalign"}, 32'(misalign_a), 32'(e.mis));
        chk({tag, " pc_plus"}, pc_plus_a, e.pc + 32'd4);
        chk({tag, " pc_valid"}, 32'(pc_valid_a), 32'd1);
      end else begin
        chk({tag, " pc"}, pc_b, e.pc);
        chk({tag, " epc"}, epc_b, e.epc);
        chk({tag, " redirect"}, 32'(redirect_b), 32'(e.red));
        chk({tag, " misalign"}, 32'(misalign_b), 32'(e.mis));
        chk({tag, " pc_plus"}, pc_plus_b, e.pc + 32'd2);
        chk({tag, " pc_valid"}, 32'(pc_valid_b), 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // word-aligned instance, starting from pc=0 after boot
    va[0]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h4,        32'h0,    0,0);
    va[1]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h8,        32'h0,    0,0);
    va[2]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'hC,        32'h0,    0,0);
    va[3]  = mk(0,0,0,0,0, 32'h0,        32'h0,        32'hC,        32'h0,    0,0);
    va[4]  = mk(0,0,1,0,1, 32'h100,      32'h0,        32'hC,        32'h0,    0,0);
    va[5]  = mk(1,0,1,0,0, 32'h14,       32'h0,        32'h20,       32'h0,    1,0);
    va[6]  = mk(1,1,0,0,0, 32'hFFFF_FFF8, 32'h0,       32'h18,       32'h0,    1,0);
    va[7]  = mk(1,0,1,0,0, 32'h100,      32'h0,        32'h118,      32'h0,    1,0);
    va[8]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h11C,      32'h0,    0,0);
    va[9]  = mk(1,0,0,1,0, 32'h3,        32'h1001,     32'h1004,     32'h0,    1,0);
    va[10] = mk(1,0,0,1,0, 32'h2,        32'h1000,     32'h100,      32'h1004, 1,1);
    va[11] = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h104,      32'h1004, 0,0);
    va[12] = mk(1,0,1,0,0, 32'hFFFF_FF2C, 32'h0,       32'h30,       32'h1004, 1,0);
    va[13] = mk(1,0,1,0,1, 32'h6,        32'h0,        32'h100,      32'h30,   1,0);
    va[14] = mk(1,1,0,1,0, 32'h8,        32'h200,      32'h208,      32'h30,   1,0);
    va[15] = mk(1,0,0,0,1, 32'h0,        32'h0,        32'h100,      32'h208,  1,0);
    va[16] = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h104,      32'h208,  0,0);
    va[17] = mk(1,0,1,0,0, 32'h2,        32'h0,        32'h100,      32'h104,  1,1);
    va[18] = mk(1,1,0,0,0, 32'h3,        32'h0,        32'h100,      32'h100,  1,1);
    va[19] = mk(0,0,0,0,0, 32'h0,        32'h0,        32'h100,      32'h100,  0,0);
    va[20] = mk(1,0,0,1,0, 32'h20,       32'hFFFF_FFF0, 32'h10,      32'h100,  1,0);
    va[21] = mk(1,0,1,0,0, 32'hFFFF_FFEC, 32'h0,       32'hFFFF_FFFC, 32'h100, 1,0);
    va[22] = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h100,  0,0);
    va[23] = mk(1,0,1,0,0, 32'h40,       32'h0,        32'h40,       32'h100,  1,0);
    va[24] = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h4,        32'h0,    0,0);
    // halfword-aligned instance
    vb[0]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h2,        32'h0,    0,0);
    vb[1]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h4,        32'h0,    0,0);
    vb[2]  = mk(1,0,1,0,0, 32'h1E,       32'h0,        32'h22,       32'h0,    1,0);
    vb[3]  = mk(1,0,0,1,0, 32'h1,        32'h20,       32'h20,       32'h0,    1,0);
    vb[4]  = mk(1,0,1,0,0, 32'h1,        32'h0,        32'h100,      32'h20,   1,1);
    vb[5]  = mk(1,0,0,0,0, 32'h0,        32'h0,        32'h102,      32'h20,   0,0);

    // Reset state and BOOT cycle (control inputs must be ignored in BOOT)
    #2;
    chk("rst pc", pc_a, 32'h0);
    chk("rst pc_valid", 32'(pc_valid_a), 32'd0);
    chk("rst epc", epc_a, 32'h0);
    chk("rst redirect", 32'(redirect_a), 32'd0);
    chk("rst misalign", 32'(misalign_a), 32'd0);
    chk("rst pc_plus", pc_plus_a, 32'h4);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1; jal = 1'b1; imm = 32'h40;
    #1;
    chk("boot pc_valid", 32'(pc_valid_a), 32'd0);
    @(posedge clk);
    #1;
    chk("boot_exit pc", pc_a, 32'h0);
    chk("boot_exit pc_valid", 32'(pc_valid_a), 32'd1);
    chk("boot_exit redirect", 32'(redirect_a), 32'd0);
    idle();

    for (int i = 0; i < 24; i++) apply(va[i], 1'b0, i);

    // Asynchronous reset mid-run with pc=0x40
    #2;
    rst = 1'b1;
    #1;
    chk("midrst pc", pc_a, 32'h0);
    chk("midrst pc_valid", 32'(pc_valid_a), 32'd0);
    chk("midrst epc", epc_a, 32'h0);
    chk("midrst redirect", 32'(redirect_a), 32'd0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("reboot pc", pc_a, 32'h0);
    chk("reboot pc_valid", 32'(pc_valid_a), 32'd1);
    apply(va[24], 1'b0, 24);

    // Halfword-aligned instance
    @(negedge clk);
    idle();
    rst_c = 1'b0;
    #1;
    chk("c boot pc_valid", 32'(pc_valid_b), 32'd0);
    chk("c boot pc_plus", pc_plus_b, 32'h2);
    @(posedge clk);
    #1;
    chk("c boot_exit pc", pc_b, 32'h0);
    chk("c boot_exit pc_valid", 32'(pc_valid_b), 32'd1);
    for (int i = 0; i < 6; i++) apply(vb[i], 1'b1, i);

    @(negedge clk);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
